// File: rtl/crp16_alu_logic_issue_if.sv
// Issue-stage bus: instruction handshake, register-file read ports and the operand
// handshake towards the logic unit.
interface crp16_alu_logic_issue_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_instr;
  logic [2:0]       rx_addr;
  logic [2:0]       ry_addr;
  logic [WIDTH-1:0] rx_data;
  logic [WIDTH-1:0] ry_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_y;
  logic [1:0]       out_select;
  logic [2:0]       out_rd;
  logic             err_illegal;
  logic [CNT_W-1:0] issue_count;

  modport slave (
    input  in_valid, in_instr, rx_data, ry_data, out_ready,
    output in_ready, rx_addr, ry_addr, out_valid, out_x, out_y, out_select, out_rd,
           err_illegal, issue_count
  );

  modport master (
    output in_valid, in_instr, rx_data, ry_data, out_ready,
    input  in_ready, rx_addr, ry_addr, out_valid, out_x, out_y, out_select, out_rd,
           err_illegal, issue_count
  );
endinterface

// File: rtl/crp16_alu_logic_issue.sv
// CRP16 logic-unit issue stage: decodes AND/OR/NOT/XOR words into operands and queues
// them in a 2-entry skid buffer; non-logic words are consumed and flagged.
module crp16_alu_logic_issue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input logic                     clock,
  input logic                     reset,
  crp16_alu_logic_issue_if.slave  bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [1:0]       sel;
    logic [2:0]       rd;
  } entry_t;

  state_e           r_state;
  state_e           w_state_next;
  entry_t           r_head;
  entry_t           r_tail;
  entry_t           w_new;
  logic             r_in_ready;
  logic             r_err;
  logic [CNT_W-1:0] r_count;
  logic             w_class_logic;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_out_valid;

  assign bus.rx_addr = bus.in_instr[7:5];
  assign bus.ry_addr = bus.in_instr[3:1];

  // NOT ignores x, so x is zeroed to keep the logic unit's NOT path single-operand.
  always_comb begin
    w_class_logic = (bus.in_instr[15:13] == 3'b010);
    w_new.sel     = bus.in_instr[12:11];
    w_new.rd      = bus.in_instr[10:8];
    w_new.x       = (bus.in_instr[12:11] == 2'b10) ? '0 : bus.rx_data;
    w_new.y       = bus.in_instr[4] ? {{(WIDTH-4){1'b0}}, bus.in_instr[3:0]} : bus.ry_data;
  end

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_push   = w_accept & w_class_logic;
  assign w_pop    = w_out_valid & bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StEmpty: if (w_push) w_state_next = StOne;
      StOne: begin
        if (w_push && !w_pop)      w_state_next = StTwo;
        else if (!w_push && w_pop) w_state_next = StEmpty;
      end
      StTwo:   if (w_pop) w_state_next = StOne;
      default: w_state_next = StEmpty;
    endcase
  end

  always_comb begin
    w_out_valid     = (r_state != StEmpty);
    bus.out_valid   = w_out_valid;
    bus.in_ready    = r_in_ready;
    bus.out_x       = r_head.x;
    bus.out_y       = r_head.y;
    bus.out_select  = r_head.sel;
    bus.out_rd      = r_head.rd;
    bus.err_illegal = r_err;
    bus.issue_count = r_count;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      unique case (r_state)
        StEmpty: if (w_push) r_head <= w_new;
        StOne: begin
          if (w_push && w_pop) r_head <= w_new;
          else if (w_push)     r_tail <= w_new;
        end
        StTwo:   if (w_pop) r_head <= r_tail;
        default: ;
      endcase
    end
  end

  // Ready is registered from the next state so it never depends on out_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_ready <= 1'b1;
      r_err      <= 1'b0;
      r_count    <= '0;
    end else begin
      r_in_ready <= (w_state_next != StTwo);
      r_err      <= w_accept & ~w_class_logic;
      if (w_pop) r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_crp16_alu_logic_issue.sv
// Scoreboard bench for crp16_alu_logic_issue: directed words, expected entries queued at
// accept time and checked by a separate monitor on every pop.
module tb_crp16_alu_logic_issue;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  sel;
    logic [2:0]  rd;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   last_wait;
  exp_t sb[$];

  crp16_alu_logic_issue_if #(.WIDTH(16), .CNT_W(16)) bus ();

  crp16_alu_logic_issue #(.WIDTH(16), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one word until accepted; queue its expected entry if it is a logic word.
  task automatic issue(input logic [15:0] instr, input logic [15:0] rxd,
                       input logic [15:0] ryd, input logic push_exp, input exp_t e);
    int   waited = 0;
    logic acc    = 1'b0;
    bus.in_instr = instr;
    bus.rx_data  = rxd;
    bus.ry_data  = ryd;
    bus.in_valid = 1'b1;
    while (!acc && waited < 20) begin
      @(negedge clock);
      acc = bus.in_ready;
      @(posedge clock);
      waited++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: instr %0h not accepted in %0d cycles", instr, waited);
    end else if (push_exp) begin
      sb.push_back(e);
    end
    last_wait = waited;
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every pop must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: x=%0h y=%0h sel=%0d rd=%0d with empty scoreboard",
                 bus.out_x, bus.out_y, bus.out_select, bus.out_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.out_x, bus.out_y, bus.out_select, bus.out_rd} !== e) begin
          bad++;
          $display("FAIL pop_entry: got x=%0h y=%0h sel=%0d rd=%0d want x=%0h y=%0h sel=%0d rd=%0d",
                   bus.out_x, bus.out_y, bus.out_select, bus.out_rd, e.x, e.y, e.sel, e.rd);
        end
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = 16'h0000;
    bus.rx_data   = 16'h0000;
    bus.ry_data   = 16'h0000;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_err", 32'(bus.err_illegal), 32'd0);
    chk("rst_count", 32'(bus.issue_count), 32'd0);
    chk("rst_operands", {bus.out_x, bus.out_y}, 32'd0);
    chk("rst_sel_rd", {27'd0, bus.out_select, bus.out_rd}, 32'd0);
    reset = 1'b0;

    // Single AND from registers.
    bus.out_ready = 1'b1;
    bus.in_instr  = 16'h4124;
    #1;
    chk("rx_addr_4124", 32'(bus.rx_addr), 32'd1);
    chk("ry_addr_4124", 32'(bus.ry_addr), 32'd2);
    issue(16'h4124, 16'hF0F0, 16'h3C3C, 1'b1, '{16'hF0F0, 16'h3C3C, 2'b00, 3'd1});
    chk("and_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clock); #1;
    chk("and_count", 32'(bus.issue_count), 32'd1);

    // Immediate NOT (x forced to 0), then immediate AND (x kept).
    issue(16'h531A, 16'h1234, 16'hFFFF, 1'b1, '{16'h0000, 16'h000A, 2'b10, 3'd3});
    issue(16'h4457, 16'hABCD, 16'hFFFF, 1'b1, '{16'hABCD, 16'h0007, 2'b00, 3'd4});
    repeat (2) @(posedge clock); #1;
    chk("imm_count", 32'(bus.issue_count), 32'd3);

    // Backpressure: two XORs fill the buffer, the third waits for out_ready.
    bus.out_ready = 1'b0;
    issue(16'h5A68, 16'h1111, 16'h2222, 1'b1, '{16'h1111, 16'h2222, 2'b11, 3'd2});
    chk("bp_ready_one", 32'(bus.in_ready), 32'd1);
    issue(16'h5A68, 16'h3333, 16'h4444, 1'b1, '{16'h3333, 16'h4444, 2'b11, 3'd2});
    chk("bp_ready_two", 32'(bus.in_ready), 32'd0);
    chk("bp_head_x", 32'(bus.out_x), 32'h1111);
    fork
      begin
        repeat (3) @(posedge clock);
        #1;
        chk("bp_stall_head", 32'(bus.out_x), 32'h1111);
        bus.out_ready = 1'b1;
      end
    join_none
    issue(16'h5A68, 16'h5555, 16'h6666, 1'b1, '{16'h5555, 16'h6666, 2'b11, 3'd2});
    chk("bp_third_held", 32'(last_wait > 1), 32'd1);
    repeat (4) @(posedge clock); #1;
    chk("bp_count", 32'(bus.issue_count), 32'd6);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Illegal word: consumed, flagged for one cycle, nothing queued.
    issue(16'h0000, 16'h0000, 16'h0000, 1'b0, '0);
    chk("ill_err_pulse", 32'(bus.err_illegal), 32'd1);
    chk("ill_in_ready", 32'(bus.in_ready), 32'd1);
    chk("ill_no_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clock); #1;
    chk("ill_err_clear", 32'(bus.err_illegal), 32'd0);
    chk("ill_count", 32'(bus.issue_count), 32'd6);

    // Streaming ORs: one push and one pop per cycle, no stalls.
    bus.in_instr = 16'h4DCE;
    #1;
    chk("rx_addr_4dce", 32'(bus.rx_addr), 32'd6);
    chk("ry_addr_4dce", 32'(bus.ry_addr), 32'd7);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] xv;
      logic [15:0] yv;
      xv = 16'h1000 + 16'(i);
      yv = 16'hF000 | 16'(i * 3);
      issue(16'h4DCE, xv, yv, 1'b1, '{xv, yv, 2'b01, 3'd5});
      chk("or_no_stall", 32'(last_wait), 32'd1);
      chk("or_valid", 32'(bus.out_valid), 32'd1);
    end
    repeat (2) @(posedge clock); #1;
    chk("or_count", 32'(bus.issue_count), 32'd14);

    // Reset with a full buffer and a pending word.
    bus.out_ready = 1'b0;
    issue(16'h5A68, 16'h7777, 16'h8888, 1'b1, '{16'h7777, 16'h8888, 2'b11, 3'd2});
    issue(16'h5A68, 16'h9999, 16'hAAAA, 1'b1, '{16'h9999, 16'hAAAA, 2'b11, 3'd2});
    bus.in_instr = 16'h0000;
    bus.in_valid = 1'b1;
    reset        = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_count", 32'(bus.issue_count), 32'd0);
    chk("mid_rst_err", 32'(bus.err_illegal), 32'd0);
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clock); #1;
    chk("mid_rst_no_stale", 32'(bus.out_valid), 32'd0);
    issue(16'h4124, 16'h0F0F, 16'h5A5A, 1'b1, '{16'h0F0F, 16'h5A5A, 2'b00, 3'd1});
    repeat (2) @(posedge clock); #1;
    chk("post_rst_count", 32'(bus.issue_count), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crp16_alu_logic_issue.md
Name: crp16_alu_logic_issue

Overview:
Issue stage feeding the CRP16 ALU logic unit. Accepts one instruction word per handshake and decodes the logic-class opcodes (AND/OR/NOT/XOR) into operand values and a 2-bit logic select. Operands come from register file read ports or from an immediate. Results sit in a 2-entry skid buffer and are presented on a valid/ready interface to the execute stage. Non-logic instructions are consumed, flagged and dropped.

Parameters:
WIDTH, 16, operand data width
CNT_W, 16, width of issued-operation counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  instruction word valid
in_ready  out  1  stage can accept a word this cycle
in_instr  in  16  instruction word
rx_addr  out  3  register read address X = in_instr[7:5] (combinational)
ry_addr  out  3  register read address Y = in_instr[3:1] (combinational)
rx_data  in  WIDTH  register X value, same cycle as rx_addr
ry_data  in  WIDTH  register Y value, same cycle as ry_addr
out_valid  out  1  head entry valid
out_ready  in  1  execute stage accepts head
out_x  out  WIDTH  operand x to logic unit
out_y  out  WIDTH  operand y to logic unit
out_select  out  2  00 AND, 01 OR, 10 NOT, 11 XOR
out_rd  out  3  destination register
err_illegal  out  1  one-cycle pulse: non-logic word consumed
issue_count  out  CNT_W  number of entries popped since reset

Behaviour:
- Instruction format: [15:13] class; class 3'b010 is logic; [12:11] op maps straight to out_select; [10:8] rd; [7:5] rx; [4] imm; [3:0] imm4 when imm=1, else [3:1] ry.
- Operand y: imm=1 -> zero-extended imm4; imm=0 -> ry_data. Operand x: rx_data, except forced to 0 when op=10 (NOT); NOT acts on y only.
- Accept occurs on in_valid & in_ready. Logic class: entry pushed, visible at out_valid on the next cycle (1-cycle latency). Other class: no push; err_illegal high for exactly the next cycle.
- Buffer states: EMPTY, ONE, TWO. in_ready = (state != TWO), registered and independent of out_ready (no combinational ready path).
- Transitions: EMPTY+push->ONE; ONE+push&pop->ONE (new word becomes head on the next cycle); ONE+push->TWO; ONE+pop->EMPTY; TWO+pop->ONE; TWO ignores in_valid.
- FIFO order is strict; the head never changes while out_valid & !out_ready.
- out_valid = (state != EMPTY). out_* hold the head entry and are stable while stalled.
- issue_count increments on each pop (out_valid & out_ready) and wraps modulo 2^CNT_W.
- Reset: state EMPTY, out_valid=0, in_ready=1 in the first cycle after reset, err_illegal=0, issue_count=0, out_x/out_y/out_select/out_rd=0. Reset mid-operation discards buffered entries and any accept in that cycle; no err_illegal pulse.
- rx_addr/ry_addr are driven from in_instr every cycle, whatever in_valid is.

Test Plan:
- Single AND: reset; in_instr=16'h4124 (rd=1, rx=1, ry=2), rx_data=16'hF0F0, ry_data=16'h3C3C, out_ready=1 -> next cycle out_valid=1, out_x=F0F0, out_y=3C3C, out_select=00, out_rd=1; issue_count=1 after pop.
- Immediate NOT: in_instr = class 010, op 10, rd 3, imm 1, imm4=4'hA, rx_data=16'h1234 -> out_x=0000, out_y=000A, out_select=10, out_rd=3.
- Backpressure: out_ready=0, three back-to-back valid XOR words -> first two accepted, in_ready=0 from the cycle after the 2nd accept, 3rd held; raise out_ready -> pops in order, in_ready returns to 1, 3rd accepted, issue_count=3 after all pops.
- Illegal word: in_instr=16'h0000 valid -> in_ready stays 1, no out_valid, err_illegal=1 for exactly one cycle, issue_count unchanged.
- Simultaneous push/pop in ONE with out_ready=1 continuously for 8 OR words -> one pop per cycle, no bubbles, correct operands each cycle, issue_count=8.
- Reset mid-operation: fill to TWO, assert reset one cycle -> out_valid=0, in_ready=1, issue_count=0, no stale entry emitted afterwards.
